// File: rtl/uart_pkg.sv
// Shared register map, bit positions and TX sequencer encoding for the UART MMIO bridge.
package uart_pkg;

   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_RXDATA = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;

   localparam int unsigned ST_TX_FULL   = 0;
   localparam int unsigned ST_TX_EMPTY  = 1;
   localparam int unsigned ST_RX_EMPTY  = 2;
   localparam int unsigned ST_RX_FULL   = 3;
   localparam int unsigned ST_TX_OVF    = 4;
   localparam int unsigned ST_RX_OVF    = 5;
   localparam int unsigned ST_TX_ACTIVE = 6;

   localparam int unsigned CT_RX_IE      = 0;
   localparam int unsigned CT_TX_IE      = 1;
   localparam int unsigned CT_TX_OVF_CLR = 4;
   localparam int unsigned CT_RX_OVF_CLR = 5;

   typedef logic [1:0] tx_state_t;

   localparam tx_state_t TX_IDLE    = 2'd0;
   localparam tx_state_t TX_START   = 2'd1;
   localparam tx_state_t TX_WAIT_HI = 2'd2;
   localparam tx_state_t TX_WAIT_LO = 2'd3;

   localparam int unsigned TX_START_TIMEOUT = 15;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a pop on a full FIFO frees room for a same-cycle push.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_mmio_bridge.sv
// CPU register window in front of the UART engines: TX/RX FIFOs, TX start sequencer, interrupt.
module uart_mmio_bridge
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] access_addr,
   input  logic        reg_w_en,
   input  logic        reg_r_en,
   input  logic [31:0] w_data,
   output logic [31:0] r_data,
   output logic [7:0]  tx_data,
   output logic        tx_begin_flag,
   input  logic        tx_busy_flag,
   input  logic [7:0]  rx_data,
   input  logic        uart_int_req,
   output logic        rx_ack,
   output logic        cpu_int_req
);

   tx_state_t   state;
   logic [3:0]  wait_cnt;
   logic        in_win;
   logic [3:0]  off;
   logic        wr_txdata, wr_ctrl, rd_rxdata;
   logic        tx_full, tx_empty, tx_pop;
   logic [7:0]  tx_dout;
   logic        rx_full, rx_empty, rx_rise;
   logic [7:0]  rx_dout;
   logic        int_req_q;
   logic        rx_ie, tx_ie, tx_ovf, rx_ovf;
   logic        tx_drop, rx_drop, tx_active;
   logic [31:0] status;
   logic        unused_bits;

   assign in_win    = (access_addr[31:4] == BASE_ADDR[31:4]);
   assign off       = {access_addr[3:2], 2'b00};
   assign wr_txdata = reg_w_en & in_win & (off == OFF_TXDATA);
   assign wr_ctrl   = reg_w_en & in_win & (off == OFF_CTRL);
   assign rd_rxdata = reg_r_en & in_win & (off == OFF_RXDATA);
   assign unused_bits = ^{access_addr[1:0], w_data[31:8]};

   assign tx_active     = (state != TX_IDLE);
   assign tx_pop        = (state == TX_IDLE) & ~tx_empty & ~tx_busy_flag;
   assign tx_begin_flag = (state == TX_START);
   assign rx_rise       = uart_int_req & ~int_req_q;

   // A pop in the same cycle makes room, so only a push without a pop can overflow.
   assign tx_drop = wr_txdata & tx_full & ~tx_pop;
   assign rx_drop = rx_rise & rx_full & ~rd_rxdata;

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (wr_txdata),
      .pop   (tx_pop),
      .din   (w_data[7:0]),
      .dout  (tx_dout),
      .full  (tx_full),
      .empty (tx_empty)
   );

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (rx_rise),
      .pop   (rd_rxdata),
      .din   (rx_data),
      .dout  (rx_dout),
      .full  (rx_full),
      .empty (rx_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= TX_IDLE;
         wait_cnt <= '0;
         tx_data  <= '0;
      end else begin
         case (state)
            TX_IDLE: begin
               if (tx_pop) begin
                  tx_data <= tx_dout;
                  state   <= TX_START;
               end
            end
            TX_START: begin
               wait_cnt <= '0;
               state    <= TX_WAIT_HI;
            end
            TX_WAIT_HI: begin
               // No busy within the window means the start was lost; the byte is abandoned.
               if (tx_busy_flag) state <= TX_WAIT_LO;
               else if (wait_cnt == 4'(TX_START_TIMEOUT - 1)) state <= TX_IDLE;
               else wait_cnt <= wait_cnt + 4'd1;
            end
            TX_WAIT_LO: begin
               if (!tx_busy_flag) state <= TX_IDLE;
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_req_q   <= 1'b0;
         rx_ack      <= 1'b0;
         rx_ie       <= 1'b0;
         tx_ie       <= 1'b0;
         tx_ovf      <= 1'b0;
         rx_ovf      <= 1'b0;
         cpu_int_req <= 1'b0;
      end else begin
         int_req_q <= uart_int_req;
         rx_ack    <= rx_rise;
         if (wr_ctrl) begin
            rx_ie <= w_data[CT_RX_IE];
            tx_ie <= w_data[CT_TX_IE];
         end
         tx_ovf      <= (tx_ovf & ~(wr_ctrl & w_data[CT_TX_OVF_CLR])) | tx_drop;
         rx_ovf      <= (rx_ovf & ~(wr_ctrl & w_data[CT_RX_OVF_CLR])) | rx_drop;
         cpu_int_req <= (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_active);
      end
   end

   always_comb begin
      status               = '0;
      status[ST_TX_FULL]   = tx_full;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_RX_EMPTY]  = rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_TX_OVF]    = tx_ovf;
      status[ST_RX_OVF]    = rx_ovf;
      status[ST_TX_ACTIVE] = tx_active;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (reg_r_en && in_win) begin
         case (off)
            OFF_TXDATA: r_data <= '0;
            OFF_RXDATA: r_data <= rx_empty ? '0 : {23'd0, 1'b1, rx_dout};
            OFF_STATUS: r_data <= status;
            OFF_CTRL:   r_data <= {30'd0, tx_ie, rx_ie};
            default:    r_data <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge with a queue-level reference model checked every cycle.
module tb_uart_mmio_bridge;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] access_addr = '0;
   logic        reg_w_en = 1'b0;
   logic        reg_r_en = 1'b0;
   logic [31:0] w_data = '0;
   logic [31:0] r_data;
   logic [7:0]  tx_data;
   logic        tx_begin_flag;
   logic        tx_busy_flag = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        uart_int_req = 1'b0;
   logic        rx_ack;
   logic        cpu_int_req;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   uart_mmio_bridge #(.FIFO_DEPTH(8), .BASE_ADDR(32'h0000_0400)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .access_addr   (access_addr),
      .reg_w_en      (reg_w_en),
      .reg_r_en      (reg_r_en),
      .w_data        (w_data),
      .r_data        (r_data),
      .tx_data       (tx_data),
      .tx_begin_flag (tx_begin_flag),
      .tx_busy_flag  (tx_busy_flag),
      .rx_data       (rx_data),
      .uart_int_req  (uart_int_req),
      .rx_ack        (rx_ack),
      .cpu_int_req   (cpu_int_req)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFOs as queues, the transmitter as "idle / age since start / busy seen".
   logic [7:0]  txq[$];
   logic [7:0]  rxq[$];
   logic [7:0]  tx_seen[$];
   bit          m_tx_ovf = 0, m_rx_ovf = 0, m_rx_ie = 0, m_tx_ie = 0;
   bit          m_idle = 1, m_seen = 0, m_begin = 0, m_ack = 0, m_int = 0, m_prev = 0;
   int          m_age = 0;
   logic [7:0]  m_txd = '0;
   logic [31:0] m_r = '0;
   bit          win, act, t_pop, t_push, r_pop, rise, ovf_t, ovf_r, clr_t, clr_r;
   int          tsz, rsz;
   logic [1:0]  off;
   logic [31:0] nr;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         txq.delete(); rxq.delete();
         m_tx_ovf = 0; m_rx_ovf = 0; m_rx_ie = 0; m_tx_ie = 0;
         m_idle = 1; m_seen = 0; m_begin = 0; m_ack = 0; m_int = 0; m_prev = 0;
         m_age = 0; m_txd = '0; m_r = '0;
      end else begin
         win = (access_addr[31:4] == 28'h000_0040);
         off = access_addr[3:2];
         tsz = txq.size(); rsz = rxq.size(); act = !m_idle;
         nr = m_r;
         if (win && reg_r_en) begin
            case (off)
               2'd0: nr = '0;
               2'd1: nr = (rsz > 0) ? {23'd0, 1'b1, rxq[0]} : '0;
               2'd2: nr = {25'd0, act, m_rx_ovf, m_tx_ovf, (rsz == D), (rsz == 0), (tsz == 0), (tsz == D)};
               default: nr = {30'd0, m_tx_ie, m_rx_ie};
            endcase
         end
         m_int  = (m_rx_ie && rsz > 0) || (m_tx_ie && tsz == 0 && !act);
         t_pop  = m_idle && tsz > 0 && !tx_busy_flag;
         t_push = win && reg_w_en && off == 2'd0;
         r_pop  = win && reg_r_en && off == 2'd1 && rsz > 0;
         rise   = uart_int_req && !m_prev;
         m_begin = 0;
         if (m_idle) begin
            if (t_pop) begin
               m_txd = txq.pop_front(); m_idle = 0; m_age = 0; m_seen = 0; m_begin = 1;
            end
         end else begin
            m_age++;
            if (m_age >= 2) begin
               if (!m_seen) begin
                  if (tx_busy_flag) m_seen = 1;
                  else if (m_age == 16) m_idle = 1;
               end else if (!tx_busy_flag) m_idle = 1;
            end
         end
         ovf_t = 0;
         if (t_push) begin
            if (tsz < D || t_pop) txq.push_back(w_data[7:0]);
            else ovf_t = 1;
         end
         if (r_pop) void'(rxq.pop_front());
         ovf_r = 0;
         if (rise) begin
            if (rsz < D || r_pop) rxq.push_back(rx_data);
            else ovf_r = 1;
         end
         clr_t = 0; clr_r = 0;
         if (win && reg_w_en && off == 2'd3) begin
            m_rx_ie = w_data[0]; m_tx_ie = w_data[1]; clr_t = w_data[4]; clr_r = w_data[5];
         end
         m_tx_ovf = (m_tx_ovf && !clr_t) || ovf_t;
         m_rx_ovf = (m_rx_ovf && !clr_r) || ovf_r;
         m_ack  = rise;
         m_prev = uart_int_req;
         m_r    = nr;
      end
   end

   initial forever begin
      @(negedge clk);
      chk("r_data", r_data, m_r);
      chk("tx_data", {24'd0, tx_data}, {24'd0, m_txd});
      chk("tx_begin", {31'd0, tx_begin_flag}, {31'd0, m_begin});
      chk("rx_ack", {31'd0, rx_ack}, {31'd0, m_ack});
      chk("cpu_int", {31'd0, cpu_int_req}, {31'd0, m_int});
      if (tx_begin_flag) tx_seen.push_back(tx_data);
   end

   // Transmitter stand-in: 0 = busy 2 cycles after each start for busy_len cycles, 1 = stuck high, 2 = stuck low.
   int busy_mode = 0;
   int busy_len = 100;
   int bcnt = 0;
   initial forever begin
      @(negedge clk);
      case (busy_mode)
         0: begin
            if (tx_begin_flag) bcnt = 1;
            else if (bcnt > 0) bcnt++;
            if (bcnt >= 3 + busy_len) bcnt = 0;
            tx_busy_flag = (bcnt >= 3);
         end
         1: begin bcnt = 0; tx_busy_flag = 1'b1; end
         default: begin bcnt = 0; tx_busy_flag = 1'b0; end
      endcase
   end

   task automatic set_busy(input int m);
      @(posedge clk);
      busy_mode = m;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      access_addr = a; w_data = d; reg_w_en = 1'b1;
      @(negedge clk);
      reg_w_en = 1'b0;
   endtask

   task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      access_addr = a; reg_r_en = 1'b1;
      @(negedge clk);
      reg_r_en = 1'b0;
      d = r_data;
   endtask

   task automatic rx_byte(input logic [7:0] b);
      int n;
      @(negedge clk);
      rx_data = b; uart_int_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rx_ack && n < 5);
      chk("rx_ack_seen", {31'd0, rx_ack}, 32'd1);
      uart_int_req = 1'b0;
   endtask

   task automatic wait_tx(input int n, input int limit);
      int k;
      k = 0;
      while (tx_seen.size() < n && k < limit) begin
         @(negedge clk);
         k++;
      end
      chk("tx_count", 32'(tx_seen.size()), 32'(n));
   endtask

   logic [7:0]  exp_tx [11] = '{8'h41, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
   logic [31:0] d;

   initial begin
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_r_data", r_data, 32'h0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'h0);
      chk("rst_outs", {29'd0, tx_begin_flag, rx_ack, cpu_int_req}, 32'h0);
      rst_n = 1'b1;
      cpu_read(32'h408, d);  chk("status_reset", d, 32'h06);

      // single byte with a well-behaved transmitter
      cpu_write(32'h400, 32'h0000_0041);
      repeat (20) @(negedge clk);
      cpu_read(32'h408, d);  chk("status_tx_active", d, 32'h46);
      wait_tx(1, 50);
      repeat (120) @(negedge clk);
      cpu_read(32'h408, d);  chk("status_tx_done", d, 32'h06);

      // lost start: busy never rises, sequencer gives up after its window
      set_busy(2);
      cpu_write(32'h40C, 32'h2);
      cpu_write(32'h400, 32'h5A);
      repeat (3) @(negedge clk);
      chk("int_tx_active", {31'd0, cpu_int_req}, 32'd0);
      repeat (30) @(negedge clk);
      chk("int_tx_idle", {31'd0, cpu_int_req}, 32'd1);
      cpu_write(32'h40C, 32'h0);

      // overflow with a stuck transmitter
      set_busy(1);
      for (int i = 1; i <= 9; i++) cpu_write(32'h400, 32'(i));
      cpu_read(32'h408, d);  chk("status_tx_ovf", d, 32'h15);
      cpu_write(32'h40C, 32'h10);
      cpu_read(32'h408, d);  chk("status_ovf_clr", d, 32'h05);

      // push into a full TX FIFO on the very edge the sequencer pops
      set_busy(2);
      @(negedge clk);
      access_addr = 32'h400; w_data = 32'hAA; reg_w_en = 1'b1;
      @(posedge clk);
      busy_mode = 1;
      @(negedge clk);
      reg_w_en = 1'b0;
      cpu_read(32'h408, d);  chk("status_tx_simul", d, 32'h45);

      busy_len = 10;
      set_busy(0);
      wait_tx(11, 2000);
      for (int i = 0; i < 11; i++) chk("tx_order", {24'd0, tx_seen[i]}, {24'd0, exp_tx[i]});
      repeat (30) @(negedge clk);
      cpu_read(32'h408, d);  chk("status_tx_drained", d, 32'h06);

      // single received byte
      rx_byte(8'hA5);
      cpu_read(32'h404, d);  chk("rxdata_a5", d, 32'h1A5);
      cpu_read(32'h404, d);  chk("rxdata_empty", d, 32'h000);

      // RX overflow with interrupt enabled
      cpu_write(32'h40C, 32'h1);
      rx_byte(8'h10);
      @(negedge clk);
      chk("int_rx_first", {31'd0, cpu_int_req}, 32'd1);
      for (int i = 1; i < 9; i++) rx_byte(8'(8'h10 + i));
      cpu_read(32'h408, d);  chk("status_rx_ovf", d, 32'h2A);
      for (int i = 0; i < 8; i++) begin
         cpu_read(32'h404, d);
         chk("rx_drain", d, 32'h110 + 32'(i));
      end
      chk("int_after_last_pop", {31'd0, cpu_int_req}, 32'd1);
      @(negedge clk);
      chk("int_fallen", {31'd0, cpu_int_req}, 32'd0);
      cpu_write(32'h40C, 32'h20);
      cpu_read(32'h408, d);  chk("status_rx_clr", d, 32'h06);

      // RX push and CPU pop on the same edge with the FIFO full
      for (int i = 0; i < 8; i++) rx_byte(8'(8'h30 + i));
      cpu_read(32'h408, d);  chk("status_rx_full", d, 32'h0A);
      @(negedge clk);
      rx_data = 8'h77; uart_int_req = 1'b1; access_addr = 32'h404; reg_r_en = 1'b1;
      @(negedge clk);
      reg_r_en = 1'b0;
      chk("rx_simul_read", r_data, 32'h130);
      chk("rx_simul_ack", {31'd0, rx_ack}, 32'd1);
      uart_int_req = 1'b0;
      cpu_read(32'h408, d);  chk("status_rx_simul", d, 32'h0A);
      for (int i = 1; i < 8; i++) begin
         cpu_read(32'h404, d);
         chk("rx_simul_drain", d, 32'h130 + 32'(i));
      end
      cpu_read(32'h404, d);  chk("rx_simul_last", d, 32'h177);

      // decode window and read-only registers
      cpu_read(32'h408, d);
      cpu_read(32'h410, d);  chk("read_out_of_window", d, 32'h06);
      cpu_write(32'h500, 32'h99);
      cpu_read(32'h408, d);  chk("write_out_of_window", d, 32'h06);
      cpu_read(32'h400, d);  chk("txdata_read", d, 32'h0);
      cpu_write(32'h40C, 32'h3);
      cpu_read(32'h40C, d);  chk("ctrl_read", d, 32'h3);
      cpu_write(32'h40C, 32'h0);

      // reset while a byte is on the wire
      busy_len = 100;
      cpu_write(32'h400, 32'h33);
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_tx_data", {24'd0, tx_data}, 32'h0);
      chk("midrst_r_data", r_data, 32'h0);
      rst_n = 1'b1;
      cpu_read(32'h408, d);  chk("status_after_midrst", d, 32'h06);

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/uart_mmio_bridge.md
Name: uart_mmio_bridge

Overview:
Memory-mapped register and buffering stage between the CPU data bus and the UART core (tx/rx engines).
- Accepts CPU register writes into a TX FIFO and drains the FIFO into the UART transmitter one byte at a time.
- Captures each byte the UART receiver signals into an RX FIFO for the CPU to read.
- Generates a maskable CPU interrupt.
- Address window: 0x0000_0400–0x0000_040F.

Parameters:
- FIFO_DEPTH, 8, entries per FIFO (power of two, 2..64).
- BASE_ADDR, 32'h0000_0400, base of the 16-byte register window.

Ports:
- clk  in  1  system clock, 50 MHz; all logic on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- access_addr  in  32  CPU bus address.
- reg_w_en  in  1  CPU write strobe, one cycle per access.
- reg_r_en  in  1  CPU read strobe, one cycle per access.
- w_data  in  32  CPU write data.
- r_data  out  32  CPU read data, registered.
- tx_data  out  8  byte to UART transmitter.
- tx_begin_flag  out  1  one-cycle start pulse to transmitter.
- tx_busy_flag  in  1  transmitter busy.
- rx_data  in  8  byte from UART receiver.
- uart_int_req  in  1  UART "byte received" level; held high until acknowledged.
- rx_ack  out  1  one-cycle acknowledge to UART; clears uart_int_req.
- cpu_int_req  out  1  interrupt to CPU.

Behaviour:
- Reset (rst_n=0, async): FIFOs empty, enables and sticky flags 0, TX FSM in TX_IDLE.
  - Outputs: r_data=0, tx_data=0, tx_begin_flag=0, rx_ack=0, cpu_int_req=0.
- Register map (offset from BASE_ADDR). An access decodes only when access_addr[31:4]==BASE_ADDR[31:4]; an address is selected by bits [3:2].
  - 0x0 TXDATA. Write pushes w_data[7:0]; read returns 0.
  - 0x4 RXDATA. Read returns {23'd0, valid, byte} and pops if not empty; empty FIFO returns 0. Write is ignored.
  - 0x8 STATUS, read-only:
    - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full;
    - bit4 tx_ovf, bit5 rx_ovf, bit6 tx_active.
  - 0xC CTRL. Write: bit0 rx_ie, bit1 tx_ie, bit4 W1C tx_ovf, bit5 W1C rx_ovf. Read returns {30'd0, tx_ie, rx_ie}.
- Read latency: r_data is valid the cycle after reg_r_en and holds until the next read. Out-of-window reads leave r_data unchanged.
- TX push when full: byte dropped, tx_ovf set (sticky).
- RX capture:
  - A rising edge of uart_int_req (0 in the previous cycle, 1 now) pushes rx_data.
  - rx_ack pulses for one cycle in the following cycle.
  - If the RX FIFO is full, the byte is dropped, rx_ovf is set, and rx_ack still pulses.
- Simultaneous push and pop on the same FIFO:
  - Both occur; count is unchanged.
  - On a full FIFO the push succeeds and there is no overflow.
  - On an empty FIFO the pop returns the empty value and the push lands.
- TX FSM:
  - TX_IDLE: when the FIFO is not empty and tx_busy_flag=0, pop the head into the tx_data register, then go to TX_START.
  - TX_START: tx_begin_flag=1 for exactly one cycle, then go to TX_WAIT_HI.
  - TX_WAIT_HI: wait for tx_busy_flag=1, then go to TX_WAIT_LO. After 15 cycles without busy, return to TX_IDLE (lost start; byte discarded).
  - TX_WAIT_LO: wait for tx_busy_flag=0, then return to TX_IDLE.
  - tx_active=1 in any state other than TX_IDLE.
  - tx_data holds its value from pop until the next pop.
- cpu_int_req (registered, one-cycle lag) = (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_active).
- Reset mid-operation aborts the FSM immediately; any byte in flight is lost.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB disambiguates full from empty, and pointers wrap naturally.

Decomposition:
- Shared package (uart_pkg):
  - register offsets OFF_TXDATA/OFF_RXDATA/OFF_STATUS/OFF_CTRL;
  - STATUS/CTRL bit indices;
  - TX state encoding;
  - TX_START_TIMEOUT=15.
- Sub-module sync_fifo (WIDTH, DEPTH; push, pop, din, dout, full, empty). It is instantiated twice: TX and RX.

Test Plan:
- Reset and idle: hold rst_n=0 mid-cycle, then release. Required: all outputs 0; STATUS read returns 0x06 (tx_empty, rx_empty).
- TX single byte: write 0x0000_0041 to 0x400 with the busy model asserting after 2 cycles and for 100 cycles. Required: exactly one tx_begin_flag pulse, tx_data=0x41; tx_active=1 throughout, then 0.
- TX overflow: with tx_busy_flag stuck at 1, write 9 bytes 0x01..0x09. Required:
  - STATUS bit0=1, bit4=1;
  - writing 0x10 to CTRL clears bit4;
  - releasing busy emits 0x01..0x08 in order.
- RX path: raise uart_int_req with rx_data=0xA5. Required:
  - rx_ack pulses once;
  - RXDATA read gives 0x1A5 one cycle later;
  - a second read gives 0x000.
- RX overflow and interrupt: set rx_ie (CTRL=0x1), then inject 9 bytes. Required: cpu_int_req=1 after the first byte; rx_ovf=1; 8 reads drain the FIFO and cpu_int_req falls one cycle after the last pop.
- Simultaneous events: TX push while full in the same cycle as the FSM pop; RX push and CPU pop in the same cycle on a full FIFO. Required: no overflow flag set and counts are unchanged.
